distance_meter_renderer: RTL

Consumer side of the distance meter's digit interface: snapshots the current-score digits, high-score glyphs and paint flag once per frame. Converts them into a stream of glyph-blit commands (screen x/y plus glyph index) over a valid/ready handshake to the sprite blitter. Sits between distance_meter and the frame compositor, and runs once per frame_start.

---
 rtl/distance_meter_pkg.sv | 44 ++++
 rtl/glyph_cmd_reg.sv | 36 +++
 rtl/distance_meter_renderer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/distance_meter_pkg.sv
// Shared constants, glyph codes and blit command type for the distance meter
// and the renderer that turns its digits into sprite-blit commands.
package distance_meter_pkg;

   localparam int MAX_DISTANCE_UNITS   = 5;
   localparam int MAX_HIGH_SCORE_UNITS = 8;
   localparam int HIGH_SCORE_OFFSET    = 3;

   localparam logic [10:0] X            = 11'd1148;
   localparam logic [10:0] HIGH_SCORE_X = 11'd948;
   localparam logic [9:0]  Y            = 10'd20;
   localparam logic [10:0] GLYPH_PITCH  = 11'd22;

   localparam logic [3:0] GLYPH_H     = 4'd10;
   localparam logic [3:0] GLYPH_I     = 4'd11;
   localparam logic [3:0] GLYPH_BLANK = 4'd12;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic [3:0]  glyph;
      logic        last;
   } blit_cmd_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      EMIT_HI    = 2'd1,
      EMIT_SCORE = 2'd2,
      FINISH     = 2'd3
   } render_state_t;

   function automatic blit_cmd_t make_cmd(input logic [10:0] base,
                                          input logic [2:0]  idx,
                                          input logic [3:0]  glyph,
                                          input logic        last);
      blit_cmd_t c;
      c.x     = base + GLYPH_PITCH * {8'd0, idx};
      c.y     = Y;
      c.glyph = glyph;
      c.last  = last;
      return c;
   endfunction

endpackage

// File: rtl/glyph_cmd_reg.sv
// Single-entry output register for blit commands: holds its payload while the
// consumer stalls and accepts a new entry whenever it is empty or draining.
module glyph_cmd_reg
   import distance_meter_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid_i,
   input  blit_cmd_t in_cmd_i,
   output logic      in_ready_o,
   output logic      out_valid_o,
   output blit_cmd_t out_cmd_o,
   input  logic      out_ready_i
);

   logic      valid_q;
   blit_cmd_t cmd_q;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_cmd_o   = cmd_q;

   // Output stage register; payload only changes on an empty slot or a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         cmd_q   <= '0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         if (in_valid_i) begin
            cmd_q <= in_cmd_i;
         end
      end
   end

endmodule

// File: rtl/distance_meter_renderer.sv
// Snapshots the score digits, high-score glyphs and paint flag on frame_start
// and streams one glyph-blit command per glyph to the sprite blitter.
module distance_meter_renderer
   import distance_meter_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 frame_start,
   input  logic [MAX_DISTANCE_UNITS-1:0][3:0]   digits,
   input  logic [MAX_HIGH_SCORE_UNITS-1:0][3:0] high_score,
   input  logic                                 paint,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overrun,
   output logic                                 cmd_valid,
   input  logic                                 cmd_ready,
   output logic [10:0]                          cmd_x,
   output logic [9:0]                           cmd_y,
   output logic [3:0]                           cmd_glyph,
   output logic                                 cmd_last
);

   render_state_t                          state_q, state_d;
   logic [2:0]                             idx_q, idx_d;
   logic [MAX_DISTANCE_UNITS-1:0][3:0]     snap_digits_q;
   logic [MAX_HIGH_SCORE_UNITS-1:0][3:0]   snap_hi_q;
   logic                                   snap_paint_q;
   logic                                   busy_q, done_q, overrun_q;

   logic      hi_en_s, xfer_s, reg_ready_s, src_valid_s;
   blit_cmd_t src_cmd_s, out_cmd_s;

   assign hi_en_s = |high_score[MAX_HIGH_SCORE_UNITS-1:HIGH_SCORE_OFFSET];
   assign xfer_s  = cmd_valid && cmd_ready;

   // Next command selection: idx_q is the index currently held in the output register.
   // The first command comes from the live inputs so cmd_valid rises one cycle after frame_start.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      src_valid_s = 1'b0;
      src_cmd_s   = '0;
      case (state_q)
         IDLE: begin
            if (frame_start && reg_ready_s) begin
               idx_d = 3'd0;
               if (hi_en_s) begin
                  state_d     = EMIT_HI;
                  src_valid_s = 1'b1;
                  src_cmd_s   = make_cmd(HIGH_SCORE_X, 3'd0, high_score[0], 1'b0);
               end else if (paint) begin
                  state_d     = EMIT_SCORE;
                  src_valid_s = 1'b1;
                  src_cmd_s   = make_cmd(X, 3'd0, digits[0], 1'b0);
               end else begin
                  state_d = FINISH;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EMIT_HI: begin
            if (xfer_s) begin
               if (idx_q == 3'd7) begin
                  idx_d = 3'd0;
                  if (snap_paint_q) begin
                     state_d     = EMIT_SCORE;
                     src_valid_s = 1'b1;
                     src_cmd_s   = make_cmd(X, 3'd0, snap_digits_q[0], 1'b0);
                  end else begin
                     state_d = FINISH;
                  end
               end else begin
                  idx_d       = idx_q + 3'd1;
                  src_valid_s = 1'b1;
                  src_cmd_s   = make_cmd(HIGH_SCORE_X, idx_q + 3'd1, snap_hi_q[idx_q + 3'd1],
                                         (idx_q == 3'd6) && !snap_paint_q);
               end
            end else begin
               state_d = EMIT_HI;
            end
         end
         EMIT_SCORE: begin
            if (xfer_s) begin
               if (idx_q == 3'd4) begin
                  idx_d   = 3'd0;
                  state_d = FINISH;
               end else begin
                  idx_d       = idx_q + 3'd1;
                  src_valid_s = 1'b1;
                  src_cmd_s   = make_cmd(X, idx_q + 3'd1, snap_digits_q[idx_q + 3'd1],
                                         idx_q == 3'd3);
               end
            end else begin
               state_d = EMIT_SCORE;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Frame control: state, snapshot and registered status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         idx_q         <= 3'd0;
         snap_digits_q <= '0;
         snap_hi_q     <= '0;
         snap_paint_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (state_q == IDLE && frame_start) begin
            snap_digits_q <= digits;
            snap_hi_q     <= high_score;
            snap_paint_q  <= paint;
         end
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_q == FINISH);
         overrun_q <= frame_start && (state_q != IDLE);
      end
   end

   glyph_cmd_reg u_cmd_reg (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (src_valid_s),
      .in_cmd_i    (src_cmd_s),
      .in_ready_o  (reg_ready_s),
      .out_valid_o (cmd_valid),
      .out_cmd_o   (out_cmd_s),
      .out_ready_i (cmd_ready)
   );

   assign cmd_x     = out_cmd_s.x;
   assign cmd_y     = out_cmd_s.y;
   assign cmd_glyph = out_cmd_s.glyph;
   assign cmd_last  = out_cmd_s.last;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule
